digit_load_seq: RTL and testbench

DIGIT_LOAD_SEQ -- requirements
Module: digit_load_seq

---
 rtl/digit_load_seq.sv | 209 ++++++++++++++++++++
 tb/tb_digit_load_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_load_seq.sv
// Character-driven load sequencer for a MM:SS clock and alarm.
// 't'/'T' starts a time load (clock frozen while loading), 'a'/'A' starts an
// alarm load, 'e'/'E' and 'd'/'D' arm and disarm the alarm. Four digits follow
// (M tens, M ones, S tens, S ones), each producing a one-cycle load strobe.
// ESC aborts a load; an idle gap of TIMEOUT_CYC cycles aborts it with err.
// Every output comes straight from a flop, so nothing combinational reaches
// the outputs from rx_data.
module digit_load_seq #(
  parameter int unsigned TIMEOUT_CYC = 60_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data_rdy,
  input  logic [7:0] rx_data,
  output logic       run,
  output logic       alarm_ena,
  output logic       ld_time,
  output logic       ld_alarm,
  output logic       ldMtens,
  output logic       ldMones,
  output logic       ldStens,
  output logic       ldSones,
  output logic [3:0] ld_num,
  output logic       err
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] ChEsc    = 8'h1B;
  localparam logic [7:0] ChZero   = 8'h30;
  localparam logic [7:0] ChFive   = 8'h35;
  localparam logic [7:0] ChNine   = 8'h39;
  localparam logic [7:0] ChUpA    = 8'h41;
  localparam logic [7:0] ChUpD    = 8'h44;
  localparam logic [7:0] ChUpE    = 8'h45;
  localparam logic [7:0] ChUpT    = 8'h54;
  localparam logic [7:0] ChLoA    = 8'h61;
  localparam logic [7:0] ChLoD    = 8'h64;
  localparam logic [7:0] ChLoE    = 8'h65;
  localparam logic [7:0] ChLoT    = 8'h74;

  typedef enum logic [2:0] {
    StIdle,
    StDMt,
    StDMo,
    StDSt,
    StDSo
  } state_e;

  typedef enum logic {
    ModeTime,
    ModeAlarm
  } mode_e;

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic            run_q, run_d;
  logic            alarm_ena_q, alarm_ena_d;
  logic            ld_time_q, ld_time_d;
  logic            ld_alarm_q, ld_alarm_d;
  logic [3:0]      strb_q, strb_d;      // {Mtens, Mones, Stens, Sones}
  logic [3:0]      ld_num_q, ld_num_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic is_esc;
  logic is_d05;
  logic is_d09;
  logic digit_ok;

  // Character classification for the digit states.
  always_comb begin
    is_esc   = (rx_data == ChEsc);
    is_d05   = (rx_data >= ChZero) && (rx_data <= ChFive);
    is_d09   = (rx_data >= ChZero) && (rx_data <= ChNine);
    digit_ok = 1'b0;
    case (state_q)
      StDMt, StDSt: digit_ok = is_d05;
      StDMo, StDSo: digit_ok = is_d09;
      default:      digit_ok = 1'b0;
    endcase
  end

  // Next-state logic: command decode in idle, digit/ESC/timeout handling while loading.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    run_d       = run_q;
    alarm_ena_d = alarm_ena_q;
    strb_d      = 4'b0000;
    ld_num_d    = 4'h0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_data_rdy) begin
          case (rx_data)
            ChLoT, ChUpT: begin
              mode_d  = ModeTime;
              state_d = StDMt;
              run_d   = 1'b0;
            end
            ChLoA, ChUpA: begin
              mode_d  = ModeAlarm;
              state_d = StDMt;
              run_d   = 1'b1;
            end
            ChLoE, ChUpE: alarm_ena_d = 1'b1;
            ChLoD, ChUpD: alarm_ena_d = 1'b0;
            default: ;
          endcase
        end
      end

      StDMt, StDMo, StDSt, StDSo: begin
        // A character arriving on the timeout cycle wins over the timeout.
        if (rx_data_rdy) begin
          cnt_d = '0;
          if (is_esc) begin
            state_d = StIdle;
            run_d   = 1'b1;
          end else if (digit_ok) begin
            ld_num_d = rx_data[3:0];
            case (state_q)
              StDMt: begin
                strb_d  = 4'b1000;
                state_d = StDMo;
              end
              StDMo: begin
                strb_d  = 4'b0100;
                state_d = StDSt;
              end
              StDSt: begin
                strb_d  = 4'b0010;
                state_d = StDSo;
              end
              default: begin
                strb_d  = 4'b0001;
                state_d = StIdle;
                run_d   = 1'b1;
              end
            endcase
          end else begin
            err_d = 1'b1;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          run_d   = 1'b1;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        run_d   = 1'b1;
        cnt_d   = '0;
      end
    endcase

    // Level outputs follow the next state so they line up with the registered state.
    ld_time_d  = (state_d != StIdle) && (mode_d == ModeTime);
    ld_alarm_d = (state_d != StIdle) && (mode_d == ModeAlarm);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= ModeTime;
      run_q       <= 1'b1;
      alarm_ena_q <= 1'b0;
      ld_time_q   <= 1'b0;
      ld_alarm_q  <= 1'b0;
      strb_q      <= 4'b0000;
      ld_num_q    <= 4'h0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      run_q       <= run_d;
      alarm_ena_q <= alarm_ena_d;
      ld_time_q   <= ld_time_d;
      ld_alarm_q  <= ld_alarm_d;
      strb_q      <= strb_d;
      ld_num_q    <= ld_num_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign run       = run_q;
  assign alarm_ena = alarm_ena_q;
  assign ld_time   = ld_time_q;
  assign ld_alarm  = ld_alarm_q;
  assign ldMtens   = strb_q[3];
  assign ldMones   = strb_q[2];
  assign ldStens   = strb_q[1];
  assign ldSones   = strb_q[0];
  assign ld_num    = ld_num_q;
  assign err       = err_q;

endmodule

// File: tb/tb_digit_load_seq.sv
// Directed bench for digit_load_seq with a short timeout.
module tb_digit_load_seq;

  localparam int unsigned TO = 100;

  logic       clk;
  logic       rst;
  logic       rx_data_rdy;
  logic [7:0] rx_data;
  logic       run;
  logic       alarm_ena;
  logic       ld_time;
  logic       ld_alarm;
  logic       ldMtens;
  logic       ldMones;
  logic       ldStens;
  logic       ldSones;
  logic [3:0] ld_num;
  logic       err;
  logic [3:0] strb;

  int n_checks = 0;
  int n_errors = 0;

  digit_load_seq #(
    .TIMEOUT_CYC(TO)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data_rdy(rx_data_rdy),
    .rx_data    (rx_data),
    .run        (run),
    .alarm_ena  (alarm_ena),
    .ld_time    (ld_time),
    .ld_alarm   (ld_alarm),
    .ldMtens    (ldMtens),
    .ldMones    (ldMones),
    .ldStens    (ldStens),
    .ldSones    (ldSones),
    .ld_num     (ld_num),
    .err        (err)
  );

  assign strb = {ldMtens, ldMones, ldStens, ldSones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one character for one cycle; returns 1 ns after the edge that samples it.
  task automatic send(input logic [7:0] ch);
    @(negedge clk);
    rx_data_rdy = 1'b1;
    rx_data     = ch;
    @(posedge clk);
    #1;
    rx_data_rdy = 1'b0;
    rx_data     = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_err;
    int n_err;

    rst         = 1'b1;
    rx_data_rdy = 1'b0;
    rx_data     = 8'h00;
    #3;
    check_eq("rst_run", run, 1);
    check_eq("rst_alarm_ena", alarm_ena, 0);
    check_eq("rst_strb", strb, 4'b0000);
    check_eq("rst_ld_num", ld_num, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_ld_time", ld_time, 0);
    check_eq("rst_ld_alarm", ld_alarm, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Time load 1 2 3 4
    send("t");
    check_eq("t_run", run, 0);
    check_eq("t_ld_time", ld_time, 1);
    check_eq("t_strb", strb, 4'b0000);
    send("1");
    check_eq("t1_strb", strb, 4'b1000);
    check_eq("t1_num", ld_num, 1);
    check_eq("t1_run", run, 0);
    tick();
    check_eq("t1_strb_off", strb, 4'b0000);
    send("2");
    check_eq("t2_strb", strb, 4'b0100);
    check_eq("t2_num", ld_num, 2);
    send("3");
    check_eq("t3_strb", strb, 4'b0010);
    check_eq("t3_num", ld_num, 3);
    send("4");
    check_eq("t4_strb", strb, 4'b0001);
    check_eq("t4_num", ld_num, 4);
    check_eq("t4_run", run, 1);
    check_eq("t4_ld_time", ld_time, 0);
    tick();
    check_eq("t4_strb_off", strb, 4'b0000);

    // Alarm load with a rejected digit
    send("a");
    check_eq("a_run", run, 1);
    check_eq("a_ld_alarm", ld_alarm, 1);
    send("7");
    check_eq("a7_err", err, 1);
    check_eq("a7_strb", strb, 4'b0000);
    tick();
    check_eq("a7_err_off", err, 0);
    send("5");
    check_eq("a5_strb", strb, 4'b1000);
    check_eq("a5_num", ld_num, 5);
    send(":");
    check_eq("acolon_err", err, 1);
    send("9");
    check_eq("a9_strb", strb, 4'b0100);
    check_eq("a9_num", ld_num, 9);
    check_eq("a9_ld_alarm", ld_alarm, 1);
    send("6");
    check_eq("a6_st_err", err, 1);
    send("0");
    check_eq("a0_strb", strb, 4'b0010);
    check_eq("a0_num", ld_num, 0);
    send("0");
    check_eq("a00_strb", strb, 4'b0001);
    check_eq("a00_num", ld_num, 0);
    check_eq("a00_run", run, 1);
    check_eq("a00_ld_alarm", ld_alarm, 0);

    // Abort with ESC
    send("T");
    send("2");
    check_eq("esc_t2_strb", strb, 4'b1000);
    check_eq("esc_t2_num", ld_num, 2);
    send(8'h1B);
    check_eq("esc_strb", strb, 4'b0000);
    check_eq("esc_err", err, 0);
    check_eq("esc_run", run, 1);
    check_eq("esc_ld_time", ld_time, 0);

    // Timeout: err exactly once, TO cycles after the command edge
    send("a");
    first_err = -1;
    n_err     = 0;
    for (int i = 1; i <= TO + 20; i++) begin
      tick();
      if (err) begin
        n_err++;
        if (first_err < 0) first_err = i;
      end
    end
    check_eq("to_first", first_err, TO);
    check_eq("to_count", n_err, 1);
    check_eq("to_ld_alarm", ld_alarm, 0);
    check_eq("to_run", run, 1);
    send("3");
    check_eq("to_late_strb", strb, 4'b0000);
    check_eq("to_late_err", err, 0);

    // Character on the timeout cycle is taken, timeout dropped
    send("A");
    repeat (TO - 1) tick();
    send("1");
    check_eq("race_strb", strb, 4'b1000);
    check_eq("race_err", err, 0);
    check_eq("race_ld_alarm", ld_alarm, 1);
    send(8'h1B);

    // Alarm enable, ignored chars, and reset abort
    send("e");
    check_eq("e_alarm_ena", alarm_ena, 1);
    send("x");
    check_eq("x_err", err, 0);
    check_eq("x_alarm_ena", alarm_ena, 1);
    send("D");
    check_eq("D_alarm_ena", alarm_ena, 0);
    send("E");
    check_eq("E_alarm_ena", alarm_ena, 1);
    send("a");
    send(8'h1B);
    check_eq("esc_keeps_ena", alarm_ena, 1);
    send("t");
    send("0");
    check_eq("r_t0_strb", strb, 4'b1000);
    check_eq("r_t0_num", ld_num, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("r_alarm_ena", alarm_ena, 0);
    check_eq("r_run", run, 1);
    check_eq("r_ld_time", ld_time, 0);
    tick();
    check_eq("r_strb", strb, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    send("1");
    check_eq("post_rst_strb", strb, 4'b0000);
    check_eq("post_rst_run", run, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
